// File: rtl/mc_control_sequencer.sv
// Multi-cycle control sequencer: steps FETCH -> DECODE -> dispatched instruction states -> FETCH
// and decodes the registered state into datapath control strobes.
module mc_control_sequencer #(
  parameter int unsigned MULT_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_dispatch,
  input  logic       i_mem_ready,
  output logic [7:0] o_state,
  output logic       o_mem_read,
  output logic       o_iord,
  output logic       o_ir_write,
  output logic       o_pc_write,
  output logic       o_pc_write_cond,
  output logic       o_branch_type,
  output logic [1:0] o_pc_source,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [2:0] o_alu_op,
  output logic       o_reg_write,
  output logic [1:0] o_reg_dst,
  output logic [1:0] o_mem_to_reg,
  output logic       o_hilo_write,
  output logic       o_illegal
);

  typedef enum logic [7:0] {
    StFetch  = 8'd0,  StDecode = 8'd1,
    StSrav   = 8'd2,  StSravWb = 8'd3,  StAddi = 8'd4,  StAddiWb = 8'd5,
    StNor    = 8'd6,  StNorWb  = 8'd7,  StXori = 8'd8,  StXoriWb = 8'd9,
    StSlt    = 8'd10, StSltWb  = 8'd11, StSlti = 8'd12, StSltiWb = 8'd13,
    StBeq    = 8'd14, StBgtz   = 8'd16, StJal  = 8'd18, StMult   = 8'd20,
    StMflo   = 8'd22, StMfloWb = 8'd23, StJr   = 8'd24, StError  = 8'hFF
  } state_e;

  localparam logic [2:0] AluAdd  = 3'b000;
  localparam logic [2:0] AluSub  = 3'b001;
  localparam logic [2:0] AluSrav = 3'b010;
  localparam logic [2:0] AluNor  = 3'b011;
  localparam logic [2:0] AluXor  = 3'b100;
  localparam logic [2:0] AluSlt  = 3'b101;

  localparam logic [7:0] MultLoad = 8'(MULT_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       ir_write, pc_write, pc_write_cond, reg_write, hilo_write;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StFetch;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    o_mem_read    = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    o_branch_type = 1'b0;
    o_pc_source   = 2'b00;
    o_alu_src_a   = 1'b0;
    o_alu_src_b   = 2'b00;
    o_alu_op      = AluAdd;
    reg_write     = 1'b0;
    o_reg_dst     = 2'b00;
    o_mem_to_reg  = 2'b00;
    hilo_write    = 1'b0;
    o_illegal     = 1'b0;
    case (state_q)
      StFetch: begin
        o_mem_read  = 1'b1;
        o_alu_src_b = 2'b01;
        if (i_mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = StDecode;
        end
      end
      StDecode: begin
        o_alu_src_b = 2'b11;
        // Preloaded every DECODE; only observed once MULT is entered.
        cnt_d       = MultLoad;
        case (i_dispatch)
          8'd2, 8'd4, 8'd6, 8'd8, 8'd10, 8'd12,
          8'd14, 8'd16, 8'd18, 8'd20, 8'd22, 8'd24: state_d = state_e'(i_dispatch);
          default: state_d = StError;
        endcase
      end
      StSrav: begin
        o_alu_src_a = 1'b1;
        o_alu_op    = AluSrav;
        state_d     = StSravWb;
      end
      StNor: begin
        o_alu_src_a = 1'b1;
        o_alu_op    = AluNor;
        state_d     = StNorWb;
      end
      StSlt: begin
        o_alu_src_a = 1'b1;
        o_alu_op    = AluSlt;
        state_d     = StSltWb;
      end
      StAddi, StXori, StSlti: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = 2'b10;
        o_alu_op    = (state_q == StAddi) ? AluAdd : (state_q == StXori) ? AluXor : AluSlt;
        state_d     = (state_q == StAddi) ? StAddiWb : (state_q == StXori) ? StXoriWb : StSltiWb;
      end
      StSravWb, StNorWb, StSltWb: begin
        reg_write = 1'b1;
        o_reg_dst = 2'b01;
        state_d   = StFetch;
      end
      StAddiWb, StXoriWb, StSltiWb: begin
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      StBeq, StBgtz: begin
        o_alu_src_a   = 1'b1;
        o_alu_op      = AluSub;
        pc_write_cond = 1'b1;
        o_branch_type = (state_q == StBgtz);
        o_pc_source   = 2'b01;
        state_d       = StFetch;
      end
      StJal: begin
        pc_write     = 1'b1;
        o_pc_source  = 2'b10;
        reg_write    = 1'b1;
        o_reg_dst    = 2'b10;
        o_mem_to_reg = 2'b10;
        state_d      = StFetch;
      end
      StJr: begin
        pc_write    = 1'b1;
        o_pc_source = 2'b11;
        state_d     = StFetch;
      end
      StMult: begin
        if (cnt_q == 8'd0) begin
          hilo_write = 1'b1;
          state_d    = StFetch;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StMflo: state_d = StMfloWb;
      StMfloWb: begin
        reg_write    = 1'b1;
        o_reg_dst    = 2'b01;
        o_mem_to_reg = 2'b11;
        state_d      = StFetch;
      end
      StError: o_illegal = 1'b1;
      default: state_d = StError;
    endcase
  end

  // Enables are forced low for the whole time reset is held, not just after the state clears.
  assign o_ir_write      = ir_write & i_rst_n;
  assign o_pc_write      = pc_write & i_rst_n;
  assign o_pc_write_cond = pc_write_cond & i_rst_n;
  assign o_reg_write     = reg_write & i_rst_n;
  assign o_hilo_write    = hilo_write & i_rst_n;
  assign o_iord          = 1'b0;
  assign o_state         = state_q;

endmodule

// File: tb/tb_mc_control_sequencer.sv
// Directed bench for mc_control_sequencer: table of per-cycle vectors plus hand sequences for
// async reset, MULT length and illegal dispatch.
module tb_mc_control_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] dispatch = 8'd0;
  logic       mem_ready = 1'b0;

  logic [7:0] st4, st1;
  logic       mr4, io4, irw4, pcw4, pcc4, bt4, sa4, rw4, hw4, ill4;
  logic       mr1, io1, irw1, pcw1, pcc1, bt1, sa1, rw1, hw1, ill1;
  logic [1:0] ps4, sb4, rd4, m2r4, ps1, sb1, rd1, m2r1;
  logic [2:0] op4, op1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mc_control_sequencer #(.MULT_CYCLES(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_dispatch(dispatch), .i_mem_ready(mem_ready),
    .o_state(st4), .o_mem_read(mr4), .o_iord(io4), .o_ir_write(irw4), .o_pc_write(pcw4),
    .o_pc_write_cond(pcc4), .o_branch_type(bt4), .o_pc_source(ps4), .o_alu_src_a(sa4),
    .o_alu_src_b(sb4), .o_alu_op(op4), .o_reg_write(rw4), .o_reg_dst(rd4),
    .o_mem_to_reg(m2r4), .o_hilo_write(hw4), .o_illegal(ill4)
  );

  mc_control_sequencer #(.MULT_CYCLES(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_dispatch(dispatch), .i_mem_ready(mem_ready),
    .o_state(st1), .o_mem_read(mr1), .o_iord(io1), .o_ir_write(irw1), .o_pc_write(pcw1),
    .o_pc_write_cond(pcc1), .o_branch_type(bt1), .o_pc_source(ps1), .o_alu_src_a(sa1),
    .o_alu_src_b(sb1), .o_alu_op(op1), .o_reg_write(rw1), .o_reg_dst(rd1),
    .o_mem_to_reg(m2r1), .o_hilo_write(hw1), .o_illegal(ill1)
  );

  logic [28:0] got4, got1;
  assign got4 = {st4, mr4, io4, irw4, pcw4, pcc4, bt4, ps4, sa4, sb4, op4, rw4, rd4, m2r4, hw4, ill4};
  assign got1 = {st1, mr1, io1, irw1, pcw1, pcc1, bt1, ps1, sa1, sb1, op1, rw1, rd1, m2r1, hw1, ill1};

  // Expected output word; iord is always 0.
  function automatic logic [28:0] ctl(logic [7:0] st, logic mr, logic irw, logic pcw, logic pcc,
                                      logic bt, logic [1:0] ps, logic sa, logic [1:0] sb,
                                      logic [2:0] op, logic rw, logic [1:0] rd, logic [1:0] m2r,
                                      logic hw, logic ill);
    return {st, mr, 1'b0, irw, pcw, pcc, bt, ps, sa, sb, op, rw, rd, m2r, hw, ill};
  endfunction

  function automatic logic [28:0] e_fetch(logic rdy);
    return ctl(8'd0, 1, rdy, rdy, 0, 0, 2'b00, 0, 2'b01, 3'b000, 0, 2'b00, 2'b00, 0, 0);
  endfunction

  function automatic logic [28:0] e_dec();
    return ctl(8'd1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 3'b000, 0, 2'b00, 2'b00, 0, 0);
  endfunction

  function automatic logic [28:0] e_err();
    return ctl(8'hFF, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 2'b00, 2'b00, 0, 1);
  endfunction

  function automatic logic [28:0] e_mult(logic hw);
    return ctl(8'd20, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 2'b00, 2'b00, hw, 0);
  endfunction

  function automatic logic is_legal(logic [7:0] d);
    if ($isunknown(d)) return 1'b0;
    return d inside {8'd2, 8'd4, 8'd6, 8'd8, 8'd10, 8'd12, 8'd14, 8'd16, 8'd18, 8'd20,
                     8'd22, 8'd24};
  endfunction

  task automatic check(string name, logic [28:0] got, logic [28:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got state=%0d ctl=%h, required state=%0d ctl=%h", name, got[28:21],
               got[20:0], exp[28:21], exp[20:0]);
    end
  endtask

  task automatic drive(logic r, logic mr, logic [7:0] d);
    @(negedge clk);
    rst_n = r;
    mem_ready = mr;
    dispatch = d;
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic        mr;
    logic [7:0]  disp;
    logic [28:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(logic r, logic mr, logic [7:0] d, logic [28:0] e);
    vec_t v;
    v.rst = r; v.mr = mr; v.disp = d; v.exp = e;
    vecs.push_back(v);
  endtask

  initial begin
    logic [7:0] bad [2];
    logic [7:0] d;

    // Reset held, then ready withheld for three cycles.
    add(0, 1, 8'h00, e_fetch(0));
    for (int i = 0; i < 3; i++) add(1, 0, 8'h33, e_fetch(0));
    add(1, 1, 8'h33, e_fetch(1));
    // ADDI
    add(1, 1, 8'd4, e_dec());
    add(1, 1, 8'h33, ctl(8'd4, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 3'b000, 0, 2'b00, 2'b00, 0, 0));
    add(1, 1, 8'h33, ctl(8'd5, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 1, 2'b00, 2'b00, 0, 0));
    // MULT, four cycles
    add(1, 1, 8'h33, e_fetch(1));
    add(1, 1, 8'd20, e_dec());
    for (int i = 0; i < 3; i++) add(1, 1, 8'h33, e_mult(0));
    add(1, 1, 8'h33, e_mult(1));
    // JAL
    add(1, 1, 8'h33, e_fetch(1));
    add(1, 1, 8'd18, e_dec());
    add(1, 1, 8'h33, ctl(8'd18, 0, 0, 1, 0, 0, 2'b10, 0, 2'b00, 3'b000, 1, 2'b10, 2'b10, 0, 0));
    // JR
    add(1, 1, 8'h33, e_fetch(1));
    add(1, 1, 8'd24, e_dec());
    add(1, 1, 8'h33, ctl(8'd24, 0, 0, 1, 0, 0, 2'b11, 0, 2'b00, 3'b000, 0, 2'b00, 2'b00, 0, 0));
    // BEQ, BGTZ
    add(1, 1, 8'h33, e_fetch(1));
    add(1, 1, 8'd14, e_dec());
    add(1, 1, 8'h33, ctl(8'd14, 0, 0, 0, 1, 0, 2'b01, 1, 2'b00, 3'b001, 0, 2'b00, 2'b00, 0, 0));
    add(1, 1, 8'h33, e_fetch(1));
    add(1, 1, 8'd16, e_dec());
    add(1, 1, 8'h33, ctl(8'd16, 0, 0, 0, 1, 1, 2'b01, 1, 2'b00, 3'b001, 0, 2'b00, 2'b00, 0, 0));
    // NOR
    add(1, 1, 8'h33, e_fetch(1));
    add(1, 1, 8'd6, e_dec());
    add(1, 1, 8'h33, ctl(8'd6, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 3'b011, 0, 2'b00, 2'b00, 0, 0));
    add(1, 1, 8'h33, ctl(8'd7, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 1, 2'b01, 2'b00, 0, 0));
    // MFLO
    add(1, 1, 8'h33, e_fetch(1));
    add(1, 1, 8'd22, e_dec());
    add(1, 1, 8'h33, ctl(8'd22, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 2'b00, 2'b00, 0, 0));
    add(1, 1, 8'h33, ctl(8'd23, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 1, 2'b01, 2'b11, 0, 0));
    // SLTI
    add(1, 1, 8'h33, e_fetch(1));
    add(1, 1, 8'd12, e_dec());
    add(1, 1, 8'h33, ctl(8'd12, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 3'b101, 0, 2'b00, 2'b00, 0, 0));
    add(1, 1, 8'h33, ctl(8'd13, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 1, 2'b00, 2'b00, 0, 0));
    // Illegal dispatch 3, then async reset out of ERROR.
    add(1, 1, 8'h33, e_fetch(1));
    add(1, 1, 8'd3, e_dec());
    add(1, 1, 8'd4, e_err());
    add(1, 0, 8'd20, e_err());
    add(0, 1, 8'd4, e_fetch(0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].mr, vecs[i].disp);
      check($sformatf("vec%0d", i), got4, vecs[i].exp);
    end

    // Reset during SRAV writeback: reg_write must drop without a clock edge.
    drive(1, 1, 8'h00);
    drive(1, 0, 8'd2);
    drive(1, 0, 8'h00);
    check("srav_exec", got4,
          ctl(8'd2, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 3'b010, 0, 2'b00, 2'b00, 0, 0));
    drive(1, 0, 8'h00);
    check("srav_wb", got4,
          ctl(8'd3, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 1, 2'b01, 2'b00, 0, 0));
    #2 rst_n = 1'b0;
    #1 check("srav_wb_rst", got4, e_fetch(0));

    // Reset on the 2nd MULT cycle, then a full MULT to confirm the counter reloads.
    drive(1, 1, 8'h00);
    drive(1, 0, 8'd20);
    drive(1, 0, 8'h00);
    drive(1, 0, 8'h00);
    check("mult_c2", got4, e_mult(0));
    #2 rst_n = 1'b0;
    #1 check("mult_rst", got4, e_fetch(0));
    drive(1, 1, 8'h00);
    drive(1, 0, 8'd20);
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 8'h00);
      check($sformatf("mult_reload%0d", i), got4, e_mult(i == 3));
    end
    drive(1, 0, 8'h00);
    check("mult_reload_end", got4, e_fetch(0));

    // Single-cycle MULT instance alongside the four-cycle one.
    drive(0, 0, 8'h00);
    drive(1, 1, 8'h00);
    drive(1, 0, 8'd20);
    drive(1, 0, 8'h00);
    check("mult1_c1", got1, e_mult(1));
    check("mult4_c1", got4, e_mult(0));
    drive(1, 0, 8'h00);
    check("mult1_end", got1, e_fetch(0));

    // 8'hFF and all-X dispatch; ERROR must absorb for 10 cycles regardless of inputs.
    bad[0] = 8'hFF;
    bad[1] = 8'bxxxxxxxx;
    for (int b = 0; b < 2; b++) begin
      drive(0, 0, 8'h00);
      drive(1, 1, 8'h00);
      drive(1, 0, bad[b]);
      d = dispatch;
      drive(1, 1, 8'h00);
      if (is_legal(d)) begin
        check($sformatf("bad%0d_state", b), {got4[28:21], 21'd0}, {d, 21'd0});
      end else begin
        for (int i = 0; i < 10; i++) begin
          check($sformatf("bad%0d_err%0d", b, i), got4, e_err());
          drive(1, i[0], 8'(2 * i));
        end
        #2 rst_n = 1'b0;
        #1 check($sformatf("bad%0d_rst", b), got4, e_fetch(0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mc_control_sequencer.md
Name: mc_control_sequencer

Overview:
- Multi-cycle control state machine; consumer of the decode-stage state ROM, which maps op/funct to an 8-bit dispatch state.
- Holds the current control state, steps FETCH -> DECODE -> dispatch state -> per-instruction states -> FETCH.
- Drives all datapath control strobes (PC, memory, IR, register file, ALU, HI/LO).
- Sits between the instruction register / state ROM and the multi-cycle datapath.

Parameters:
- MULT_CYCLES, 4, cycles spent in the MULT state (legal range 1..255); HI/LO is written on the last of them.

Ports:
- i_clk  input  1  system clock, rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_dispatch  input  8  dispatch state from the state ROM; sampled only in DECODE
- i_mem_ready  input  1  instruction memory read data valid
- o_state  output  8  current state encoding
- o_mem_read  output  1  instruction memory read request
- o_iord  output  1  memory address select; always 0 (instruction fetch only)
- o_ir_write  output  1  IR load
- o_pc_write  output  1  unconditional PC write
- o_pc_write_cond  output  1  conditional PC write, qualified by branch compare
- o_branch_type  output  1  0 = equal/zero (beq), 1 = greater-than-zero (bgtz)
- o_pc_source  output  2  00 ALU, 01 ALUOut, 10 jump target, 11 register rs
- o_alu_src_a  output  1  0 PC, 1 rs
- o_alu_src_b  output  2  00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- o_alu_op  output  3  000 ADD, 001 SUB, 010 SRAV, 011 NOR, 100 XOR, 101 SLT
- o_reg_write  output  1  register file write enable
- o_reg_dst  output  2  00 rt, 01 rd, 10 $31
- o_mem_to_reg  output  2  00 ALUOut, 01 reserved, 10 PC, 11 LO
- o_hilo_write  output  1  HI/LO write enable
- o_illegal  output  1  high while in ERROR

Behaviour:
- Reset (async, i_rst_n = 0): state = 0 (FETCH), mult counter = 0.
  - o_illegal = 0.
  - All write enables (o_ir_write, o_pc_write, o_pc_write_cond, o_reg_write, o_hilo_write) held 0 while reset is asserted.
  - Reset mid-instruction aborts it immediately; there is no partial writeback after release.
- Outputs are combinational from state; o_ir_write and o_pc_write in FETCH are additionally gated by i_mem_ready. Unlisted outputs are 0 in every state.
- State 0, FETCH:
  - o_mem_read = 1, alu_src_a = 0, alu_src_b = 01, alu_op = ADD, pc_source = 00.
  - Stays in FETCH while i_mem_ready = 0.
  - When i_mem_ready = 1: ir_write = pc_write = 1 that cycle, next state = 1.
- State 1, DECODE:
  - alu_src_a = 0, alu_src_b = 11, alu_op = ADD (branch target precompute).
  - Next state = i_dispatch if it is in {2,4,6,8,10,12,14,16,18,20,22,24}.
  - Any other value, including X/Z bits, goes to ERROR (8'hFF).
- Two-state ALU instructions:
  - 2 SRAV exec (src_a 1, src_b 00, op SRAV) -> 3 R-writeback.
  - 6 NOR exec (op NOR) -> 7 R-writeback.
  - 10 SLT exec (op SLT) -> 11 R-writeback.
  - 4 ADDI exec (src_a 1, src_b 10, op ADD) -> 5 I-writeback.
  - 8 XORI exec (op XOR) -> 9 I-writeback.
  - 12 SLTI exec (op SLT) -> 13 I-writeback.
- Writeback states:
  - R-writeback (3, 7, 11): reg_write = 1, reg_dst = 01, mem_to_reg = 00 -> FETCH.
  - I-writeback (5, 9, 13): reg_write = 1, reg_dst = 00, mem_to_reg = 00 -> FETCH.
- Single-state control-flow instructions, each -> FETCH:
  - 14 BEQ: src_a 1, src_b 00, op SUB, pc_write_cond = 1, branch_type = 0, pc_source = 01.
  - 16 BGTZ: same as BEQ but branch_type = 1.
  - 18 JAL: pc_write = 1, pc_source = 10, reg_write = 1, reg_dst = 10, mem_to_reg = 10.
  - 24 JR: pc_write = 1, pc_source = 11.
- 20 MULT:
  - Counter loads MULT_CYCLES-1 on entry, decrements each cycle.
  - Stays in MULT while counter != 0.
  - On the counter = 0 cycle: hilo_write = 1, next state = FETCH.
  - Total residency is exactly MULT_CYCLES cycles; MULT_CYCLES = 1 gives a single cycle with hilo_write.
- 22 MFLO -> 23 LO-writeback: reg_write = 1, reg_dst = 01, mem_to_reg = 11 -> FETCH.
- 8'hFF ERROR: o_illegal = 1, all enables 0; absorbing until reset.
- Any unreachable state encoding goes to ERROR on the next clock.
- o_state reflects the registered state only and never glitches to the dispatch value before the clock edge.
- Inputs ignored outside their state: i_dispatch outside DECODE, i_mem_ready outside FETCH.

Test Plan:
- Reset release with i_mem_ready = 0 for 3 cycles, then 1 -> o_state holds 0 for 3 cycles; ir_write = pc_write = 1 only on the ready cycle; then o_state = 1.
- ADDI: i_mem_ready = 1, i_dispatch = 4 -> states 0, 1, 4, 5, 0; reg_write only in 5 with reg_dst = 00; ALU op ADD with src_b 10 in 4.
- MULT, MULT_CYCLES = 4, i_dispatch = 20 -> o_state = 20 for exactly 4 cycles; hilo_write = 1 only on the 4th; then state 0. Repeat with MULT_CYCLES = 1 -> one cycle with hilo_write.
- JAL (18) and JR (24) -> single execute cycle; pc_source 10 with reg_dst 10 and mem_to_reg 10 for JAL; pc_source 11 for JR; then FETCH.
- Illegal dispatch (i_dispatch = 3, 8'hFF, 8'bxxxxxxxx) -> o_state = 8'hFF, o_illegal = 1, stays there across 10 cycles; i_rst_n low -> state 0 immediately, without waiting for a clock edge.
- Async reset asserted mid-MULT (2nd cycle) and mid-R-writeback -> hilo_write and reg_write drop immediately; after release, o_state = 0 and the counter is reloaded on the next MULT entry.
